serial_master: RTL and testbench

- Register-access initiator for the byte-serial host protocol. It drives the FT245-side strobes and byte bus that the serial register slave consumes.
- It converts one parallel request (read or write, 4-bit address, 32-bit data) into the command byte plus four data bytes, LSB first, and collects read data.
- Used for on-board self-test and loopback: it sits in place of the FTDI chip in front of the serial register slave.

---
 rtl/serial_master.sv | 106 ++++++++++
 tb/tb_serial_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_master.sv
// serial_master: byte-serial register-access initiator driving FT245-style strobes into the serial register slave.
module serial_master #(
  parameter int TIMEOUT = 255,
  parameter int GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic [3:0]  req_adr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [7:0]  ft_byte_out,
  output logic        _ft_rxf,
  output logic        _ft_rd,
  output logic        _ft_wr,
  input  logic [7:0]  ft_byte_in,
  input  logic        _serial_wr,
  input  logic        _serial_rd
);
  localparam int CW = $clog2((TIMEOUT > GAP ? TIMEOUT : GAP) + 1);
  typedef enum logic [2:0] {IDLE, CMD, RD_STB, RD_CAP, WR_ACK, WR_BYTE, WR_END, GAP_S} state_t;
  state_t state, state_n;
  logic          wr;
  logic [3:0]    adr;
  logic [31:0]   wdata;
  logic [23:0]   shadow;
  logic [1:0]    k;
  logic [CW-1:0] cnt;
  logic          fin, fail;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    fin = 1'b0;
    fail = 1'b0;
    _ft_rxf = 1'b1;
    _ft_rd = 1'b1;
    _ft_wr = 1'b1;
    ft_byte_out = 8'h00;
    case (state)
      IDLE: state_n = req ? CMD : IDLE;
      CMD: begin
        _ft_rxf = 1'b0;
        ft_byte_out = {adr, wr ? 4'h5 : 4'hA};
        state_n = wr ? WR_ACK : RD_STB;
      end
      RD_STB: begin
        _ft_rd = 1'b0;
        state_n = RD_CAP;
      end
      RD_CAP: begin
        fin = k == 2'd3;
        fail = fin && !_serial_rd;
        state_n = fin ? GAP_S : RD_STB;
      end
      WR_ACK: begin
        fail = _serial_wr && cnt == CW'(TIMEOUT - 1);
        fin = fail;
        state_n = !_serial_wr ? WR_BYTE : fail ? GAP_S : WR_ACK;
      end
      WR_BYTE: begin
        _ft_wr = 1'b0;
        ft_byte_out = wdata[8*k +: 8];
        state_n = k == 2'd3 ? WR_END : WR_BYTE;
      end
      WR_END: begin
        fail = !_serial_wr && cnt == CW'(TIMEOUT - 1);
        fin = _serial_wr || fail;
        state_n = fin ? GAP_S : WR_END;
      end
      GAP_S: state_n = cnt == CW'(GAP - 1) ? IDLE : GAP_S;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr <= 1'b0;
      adr <= 4'h0;
      wdata <= 32'h0;
      shadow <= 24'h0;
      rdata <= 32'h0;
      k <= 2'd0;
      cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      done <= fin;
      err <= fail;
      // cnt counts cycles spent in the current state, so each wait starts from zero
      cnt <= state_n != state ? '0 : cnt + CW'(1);
      k <= (state == RD_CAP || state == WR_BYTE) ? k + 2'd1 : state == RD_STB ? k : 2'd0;
      if (state == IDLE && req) begin
        wr <= req_wr;
        adr <= req_adr;
        wdata <= req_wdata;
      end
      if (state == RD_CAP) shadow <= {ft_byte_in, shadow[23:8]};
      if (state == RD_CAP && fin && !fail) rdata <= {ft_byte_in, shadow};
    end
  end
endmodule

// File: tb/tb_serial_master.sv
// tb_serial_master: randomized transactions against a behavioural serial slave and a register-map reference model.
module tb_serial_master;
  localparam int TIMEOUT = 8;
  localparam int GAP = 3;
  logic        clk, reset, req, req_wr;
  logic [3:0]  req_adr;
  logic [31:0] req_wdata, rdata;
  logic        busy, done, err;
  logic [7:0]  ft_byte_out, ft_byte_in;
  logic        _ft_rxf, _ft_rd, _ft_wr, _serial_wr, _serial_rd;
  int n_cmp = 0, n_bad = 0;
  serial_master #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_adr(req_adr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .ft_byte_out(ft_byte_out),
    ._ft_rxf(_ft_rxf), ._ft_rd(_ft_rd), ._ft_wr(_ft_wr), .ft_byte_in(ft_byte_in),
    ._serial_wr(_serial_wr), ._serial_rd(_serial_rd)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // behavioural slave: registers 0..7 mapped, 8..15 read as DEADBEEF
  logic [31:0] regs [8];
  logic [1:0]  s_mode, s_nb;
  logic [2:0]  s_cnt;
  logic [3:0]  s_adr;
  logic [31:0] s_buf;
  int lat = 0;
  bit wr_dead = 0, rd_bad = 0, spam = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
      s_mode <= 0; s_nb <= 0; s_cnt <= 0; s_adr <= 0; s_buf <= 0;
      _serial_wr <= 1; _serial_rd <= 1; ft_byte_in <= 0;
    end else if (!_ft_rxf) begin
      s_adr <= ft_byte_out[7:4]; s_nb <= 0; s_cnt <= 0; _serial_wr <= 1;
      if (ft_byte_out[3:0] == 4'h5) s_mode <= 1;
      else if (ft_byte_out[3:0] == 4'hA) begin
        s_mode <= 3; _serial_rd <= 0;
        s_buf <= ft_byte_out[7] ? 32'hDEADBEEF : regs[ft_byte_out[6:4]];
      end else s_mode <= 0;
    end else case (s_mode)
      1: if (wr_dead) s_mode <= 0;
         else if (s_cnt == lat) begin _serial_wr <= 0; s_mode <= 2; end
         else s_cnt <= s_cnt + 1;
      2: if (!_ft_wr) begin
           s_buf[8*s_nb +: 8] <= ft_byte_out; s_nb <= s_nb + 1;
           if (s_nb == 3) begin
             if (!s_adr[3]) regs[s_adr[2:0]] <= {ft_byte_out, s_buf[23:0]};
             _serial_wr <= 1; s_mode <= 0;
           end
         end
      3: if (!_ft_rd) begin
           ft_byte_in <= s_buf[8*s_nb +: 8]; s_nb <= s_nb + 1;
           if (s_nb == 3) begin _serial_rd <= !rd_bad; s_mode <= 0; end
         end
      default: ;
    endcase
  end
  // reference model: register contents and expected rdata
  logic [31:0] mdl [16];
  logic [31:0] mrd = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input bit w, input logic [3:0] a, input logic [31:0] d);
    logic [7:0] wb[$];
    int rd_lo[$];
    int n = 0, cmd_at = -1, done_at = -1, dn = 0, exp_done;
    logic [7:0] cmdb = 0;
    logic e = 0;
    logic [31:0] rv = 'x;
    bit exp_err = w ? wr_dead : rd_bad;
    string t = $sformatf("%s%0h", w ? "wr" : "rd", a);
    exp_done = w ? (wr_dead ? TIMEOUT + 1 : lat + 8) : 9;
    req = 1; req_wr = w; req_adr = a; req_wdata = d;
    @(negedge clk);
    while (busy && n < 400) begin
      req = spam;
      req_wdata = ~d;
      if (!_ft_rxf) begin cmd_at = n; cmdb = ft_byte_out; end
      if (!_ft_wr) wb.push_back(ft_byte_out);
      if (!_ft_rd) rd_lo.push_back(n);
      if (done) begin dn++; done_at = n; e = err; rv = rdata; end
      n++;
      @(negedge clk);
    end
    req = 0;
    if (!exp_err) begin
      if (w) begin if (!a[3]) mdl[a] = d; end
      else mrd = a[3] ? 32'hDEADBEEF : mdl[a];
    end
    check({t, "_hang"}, busy, 0);
    check({t, "_cmd_at"}, cmd_at, 0);
    check({t, "_cmd"}, cmdb, {a, w ? 4'h5 : 4'hA});
    check({t, "_ndone"}, dn, 1);
    check({t, "_done_at"}, done_at, exp_done);
    check({t, "_err"}, e, exp_err);
    check({t, "_rdata"}, rv, mrd);
    check({t, "_gap"}, n - done_at, GAP);
    check({t, "_nwr"}, wb.size(), (w && !exp_err) ? 4 : 0);
    check({t, "_nrd"}, rd_lo.size(), w ? 0 : 4);
    for (int i = 0; i < wb.size() && i < 4; i++) check({t, "_wbyte"}, wb[i], d[8*i +: 8]);
    for (int i = 0; i < rd_lo.size(); i++) check({t, "_rd_at"}, rd_lo[i], 2 * i + 1);
  endtask
  initial begin
    int nw, dn;
    logic [31:0] v;
    reset = 1; req = 0; req_wr = 0; req_adr = 0; req_wdata = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", {done, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {_ft_rxf, _ft_rd, _ft_wr}, 3'b111);
    check("rst_byte", ft_byte_out, 0);
    reset = 0;
    @(negedge clk);
    run(1, 3, 32'h12345678);
    run(0, 3, 0);
    lat = 3;
    run(1, 4, 32'hCAFEF00D);
    run(0, 4, 0);
    run(0, 4'hF, 0);
    wr_dead = 1;
    run(1, 2, $urandom);
    wr_dead = 0;
    run(0, 2, 0);
    // reset during the second write byte
    lat = 1;
    req = 1; req_wr = 1; req_adr = 1; req_wdata = $urandom;
    @(negedge clk);
    req = 0; nw = 0;
    for (int i = 0; i < 50 && nw < 2; i++) begin
      @(negedge clk);
      if (!_ft_wr) nw++;
    end
    check("mid_reach", nw, 2);
    #1 reset = 1;
    #1;
    check("mid_strobes", {_ft_rxf, _ft_rd, _ft_wr}, 3'b111);
    check("mid_busy", busy, 0);
    check("mid_byte", ft_byte_out, 0);
    @(negedge clk);
    reset = 0;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_nodone", dn, 0);
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    mrd = 0;
    run(0, 1, 0);
    v = $urandom;
    run(1, 5, v);
    run(0, 5, 0);
    rd_bad = 1; spam = 1;
    run(0, 6, 0);
    rd_bad = 0; spam = 0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) dn++;
    end
    check("spam_ignored", dn, 0);
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(0, 5);
      spam = $urandom_range(0, 3) == 0;
      wr_dead = $urandom_range(0, 9) == 0;
      rd_bad = $urandom_range(0, 9) == 0;
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      wr_dead = 0; rd_bad = 0; spam = 0;
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
